uart_rx: RTL and testbench

//  UART 8N1 receiver; pairs with uart_tx on the same board link (same bit rate).

---
 rtl/uart_rx.sv | 127 ++++++++++++
 tb/tb_uart_rx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART 8N1 receiver: 2-flop synchronised input, centre sampling from a falling-edge
// reference, stop-bit check, and a single-entry valid/ready output register.
module uart_rx #(
  parameter int unsigned CLK_DIV = 868,
  parameter int unsigned CNT_W   = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLK_DIV - 1);

  logic             rx_m, rx_s, rx_s_d, fall;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  logic             done, done_n, ferr_p, ferr_p_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m   <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      rx_m   <= rx;
      rx_s   <= rx_m;
      rx_s_d <= rx_s;
    end
  end

  assign fall = rx_s_d & ~rx_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      done    <= 1'b0;
      ferr_p  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      done    <= done_n;
      ferr_p  <= ferr_p_n;
    end
  end

  // The stop sample returns to IDLE immediately so a start bit half a bit later is seen.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CNT_W'(1);
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    done_n    = 1'b0;
    ferr_p_n  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (fall) state_n = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            state_n = IDLE;
          end else begin
            state_n   = DATA;
            bit_idx_n = '0;
          end
        end
      end
      DATA: begin
        if (cnt == FULL_LAST) begin
          cnt_n     = '0;
          shreg_n   = {rx_s, shreg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == FULL_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (rx_s) done_n = 1'b1;
          else      ferr_p_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_p;
      overrun   <= 1'b0;
      if (done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: CLK_DIV=16 directed frames plus a CLK_DIV=868
// instance driven with +/-2% bit-period skew.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1, rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun;
  logic       rx2 = 1'b1, rx_ready2 = 1'b1;
  logic [7:0] rx_data2;
  logic       rx_valid2, frame_err2, overrun2;

  localparam logic [7:0] FL_FERR = 8'h46;
  localparam logic [7:0] FL_OVR  = 8'h4F;

  uart_rx #(.CLK_DIV(16), .CNT_W(5)) u_dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun));

  uart_rx #(.CLK_DIV(868), .CNT_W(14)) u_dut_big (
    .clk(clk), .rst(rst), .rx(rx2), .rx_data(rx_data2), .rx_valid(rx_valid2),
    .rx_ready(rx_ready2), .frame_err(frame_err2), .overrun(overrun2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0, failed = 0;
  logic [7:0] exp_q[$], flag_q[$], exp2_q[$];
  int rise_q[$];
  logic valid_d = 1'b0, ferr_d = 1'b0, ovr_d = 1'b0;
  logic [7:0] e_byte, e_flag, e_big;
  int c;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic set_line(input bit sel, input logic v);
    if (sel) rx2 = v;
    else     rx  = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input logic stopb, input int per);
    set_line(sel, 1'b0);
    idle(per);
    for (int i = 0; i < 8; i++) begin
      set_line(sel, d[i]);
      idle(per);
    end
    set_line(sel, stopb);
    idle(per);
    set_line(sel, 1'b1);
  endtask

  // Small-DUT monitor: pops expected bytes on acceptance and expected flags on pulses.
  always @(negedge clk) begin
    if (rst) begin
      if (rx_valid && !valid_d) rise_q.push_back(cyc);
      if (rx_valid && rx_ready) begin
        chk("byte_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e_byte = exp_q.pop_front();
          chk("rx_data", rx_data, e_byte);
        end
      end
      if (frame_err || overrun) begin
        chk("flag_expected", int'(flag_q.size() > 0), 1);
        if (flag_q.size() > 0) begin
          e_flag = flag_q.pop_front();
          chk("flag_kind", frame_err ? FL_FERR : FL_OVR, e_flag);
        end
      end
      if (frame_err) chk("flags_exclusive", overrun, 0);
      if (ferr_d) chk("frame_err_pulse", frame_err, 0);
      if (ovr_d)  chk("overrun_pulse", overrun, 0);
    end
    valid_d = rx_valid;
    ferr_d  = frame_err;
    ovr_d   = overrun;
  end

  always @(negedge clk) begin
    if (rst) begin
      if (rx_valid2) begin
        chk("big_byte_expected", int'(exp2_q.size() > 0), 1);
        if (exp2_q.size() > 0) begin
          e_big = exp2_q.pop_front();
          chk("big_rx_data", rx_data2, e_big);
        end
      end
      if (frame_err2 || overrun2) chk("big_no_flags", {frame_err2, overrun2}, 0);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
    $fatal(1);
  end

  initial begin
    idle(2);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_rx_data", rx_data, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_overrun", overrun, 0);
    rst = 1'b1;
    idle(5);

    // 1: single frame held until accepted
    rx_ready = 1'b0;
    rise_q.delete();
    exp_q.push_back(8'hA5);
    c = cyc;
    send_frame(0, 8'hA5, 1'b1, 16);
    chk("t1_rises", rise_q.size(), 1);
    if (rise_q.size() > 0) chk("t1_valid_cycle", rise_q[0] - c, 156);
    repeat (5) begin
      @(negedge clk);
      chk("t1_hold_valid", rx_valid, 1);
      chk("t1_hold_data", rx_data, 8'hA5);
    end
    @(posedge clk); #1 rx_ready = 1'b1;
    @(posedge clk); #1 rx_ready = 1'b0;
    @(negedge clk);
    chk("t1_valid_drop", rx_valid, 0);

    // 2: back-to-back frames
    idle(10);
    rx_ready = 1'b1;
    rise_q.delete();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    c = cyc;
    send_frame(0, 8'h00, 1'b1, 16);
    send_frame(0, 8'hFF, 1'b1, 16);
    idle(20);
    chk("t2_rises", rise_q.size(), 2);
    if (rise_q.size() == 2) begin
      chk("t2_first_cycle", rise_q[0] - c, 156);
      chk("t2_spacing", rise_q[1] - rise_q[0], 160);
    end

    // 3: framing error, then a good frame
    idle(10);
    rise_q.delete();
    flag_q.push_back(FL_FERR);
    send_frame(0, 8'h3C, 1'b0, 16);
    idle(20);
    chk("t3_no_valid", rise_q.size(), 0);
    chk("t3_ferr_seen", flag_q.size(), 0);
    exp_q.push_back(8'h55);
    send_frame(0, 8'h55, 1'b1, 16);
    idle(20);
    chk("t3_good_frame", rise_q.size(), 1);

    // 5: overrun while the first byte is pending
    rx_ready = 1'b0;
    rise_q.delete();
    exp_q.push_back(8'h11);
    flag_q.push_back(FL_OVR);
    send_frame(0, 8'h11, 1'b1, 16);
    send_frame(0, 8'h22, 1'b1, 16);
    idle(20);
    chk("t5_valid_held", rx_valid, 1);
    chk("t5_data_held", rx_data, 8'h11);
    chk("t5_overrun_seen", flag_q.size(), 0);
    rx_ready = 1'b1;
    @(posedge clk); #1 rx_ready = 1'b0;
    @(negedge clk);
    chk("t5_valid_drop", rx_valid, 0);

    // 4: short glitch rejected; FSM still receives afterwards
    idle(10);
    rise_q.delete();
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(200);
    chk("t4_no_valid", rise_q.size(), 0);
    chk("t4_valid_low", rx_valid, 0);
    send_frame(0, 8'h5A, 1'b1, 16);
    idle(10);
    chk("t4_after_valid", rx_valid, 1);
    chk("t4_after_data", rx_data, 8'h5A);

    // 6: reset during data bit 4 (line high from bit 4 on, so no false edge at release)
    rise_q.delete();
    fork
      send_frame(0, 8'hF0, 1'b1, 16);
      begin
        idle(5 * 16 + 8);
        rst = 1'b0;
        #1;
        chk("t6_rst_valid", rx_valid, 0);
        chk("t6_rst_data", rx_data, 0);
        chk("t6_rst_ferr", frame_err, 0);
        chk("t6_rst_ovr", overrun, 0);
        idle(2);
        rst = 1'b1;
      end
    join
    idle(20);
    chk("t6_nothing_delivered", rise_q.size(), 0);
    rx_ready = 1'b1;
    exp_q.push_back(8'h81);
    send_frame(0, 8'h81, 1'b1, 16);
    idle(20);
    chk("t6_fresh_frame", rise_q.size(), 1);

    // CLK_DIV=868 with +2%, -2% and nominal bit periods
    exp2_q.push_back(8'h5A);
    send_frame(1, 8'h5A, 1'b1, 885);
    exp2_q.push_back(8'hC3);
    send_frame(1, 8'hC3, 1'b1, 851);
    exp2_q.push_back(8'h96);
    send_frame(1, 8'h96, 1'b1, 868);
    idle(100);

    chk("bytes_pending", exp_q.size(), 0);
    chk("flags_pending", flag_q.size(), 0);
    chk("big_bytes_pending", exp2_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
